rs_alu_scheduler: RTL and testbench

//  Reservation station and issue scheduler for the integer ALU. Buffers decoded ALU/branch/jump ops,

---
 rtl/rs_alu_scheduler.sv | 162 ++++++++++++++++
 tb/tb_rs_alu_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_scheduler.sv
// Reservation station and issue scheduler for the integer ALU: CDB wakeup, lowest-index select, registered dispatch.
// Optional RS_WAKEUP_SELECT_EN: select also sees operands being woken this cycle (fused wakeup-select).
module rs_alu_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rdy_i,
    input  logic             rollback_i,
    input  logic             issue_sgn_i,
    input  logic [5:0]       issue_opcode_i,
    input  logic             issue_j_rdy_i,
    input  logic [31:0]      issue_vj_i,
    input  logic [ROB_W-1:0] issue_qj_i,
    input  logic             issue_k_rdy_i,
    input  logic [31:0]      issue_vk_i,
    input  logic [ROB_W-1:0] issue_qk_i,
    input  logic [31:0]      issue_imm_i,
    input  logic [31:0]      issue_pc_i,
    input  logic [ROB_W-1:0] issue_rob_i,
    output logic             rs_full_o,
    input  logic             alu_cdb_sgn_i,
    input  logic [ROB_W-1:0] alu_cdb_rob_i,
    input  logic [31:0]      alu_cdb_val_i,
    input  logic             lsb_cdb_sgn_i,
    input  logic [ROB_W-1:0] lsb_cdb_rob_i,
    input  logic [31:0]      lsb_cdb_val_i,
    output logic             rs_sgn_o,
    output logic [5:0]       rs_opcode_o,
    output logic [31:0]      lhs_o,
    output logic [31:0]      rhs_o,
    output logic [31:0]      imm_o,
    output logic [31:0]      pc_o,
    output logic [ROB_W-1:0] rob_entry_o
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] valid_q;
    logic [RS_SIZE-1:0] jr_q, kr_q, jr_d, kr_d, ready;
    logic [5:0]         op_q  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [31:0]        vk_d  [RS_SIZE];
    logic [ROB_W-1:0]   qj_q  [RS_SIZE];
    logic [ROB_W-1:0]   qk_q  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];

    logic             rs_sgn_q;
    logic [5:0]       rs_opcode_q;
    logic [31:0]      lhs_q, rhs_q, imm_out_q, pc_out_q;
    logic [ROB_W-1:0] rob_entry_q;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             iss_jr, iss_kr;
    logic [31:0]      iss_vj, iss_vk;

    // ALU broadcast checked first so it wins when both CDBs carry the same tag.
    function automatic logic [32:0] wake(
        input logic rdy, input logic [ROB_W-1:0] tag, input logic [31:0] val,
        input logic a_sgn, input logic [ROB_W-1:0] a_rob, input logic [31:0] a_val,
        input logic l_sgn, input logic [ROB_W-1:0] l_rob, input logic [31:0] l_val);
        if (rdy)                       return {1'b1, val};
        else if (a_sgn && tag == a_rob) return {1'b1, a_val};
        else if (l_sgn && tag == l_rob) return {1'b1, l_val};
        else                           return {1'b0, val};
    endfunction

    always_comb begin
        ready     = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            {jr_d[i], vj_d[i]} = wake(jr_q[i], qj_q[i], vj_q[i], alu_cdb_sgn_i, alu_cdb_rob_i,
                                      alu_cdb_val_i, lsb_cdb_sgn_i, lsb_cdb_rob_i, lsb_cdb_val_i);
            {kr_d[i], vk_d[i]} = wake(kr_q[i], qk_q[i], vk_q[i], alu_cdb_sgn_i, alu_cdb_rob_i,
                                      alu_cdb_val_i, lsb_cdb_sgn_i, lsb_cdb_rob_i, lsb_cdb_val_i);
`ifdef RS_WAKEUP_SELECT_EN
            ready[i] = valid_q[i] && jr_d[i] && kr_d[i];
`else
            ready[i] = valid_q[i] && jr_q[i] && kr_q[i];
`endif
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = i[IDX_W-1:0];
            end
            if (!valid_q[i]) free_idx = i[IDX_W-1:0];
        end
        {iss_jr, iss_vj} = wake(issue_j_rdy_i, issue_qj_i, issue_vj_i, alu_cdb_sgn_i, alu_cdb_rob_i,
                                alu_cdb_val_i, lsb_cdb_sgn_i, lsb_cdb_rob_i, lsb_cdb_val_i);
        {iss_kr, iss_vk} = wake(issue_k_rdy_i, issue_qk_i, issue_vk_i, alu_cdb_sgn_i, alu_cdb_rob_i,
                                alu_cdb_val_i, lsb_cdb_sgn_i, lsb_cdb_rob_i, lsb_cdb_val_i);
    end

    assign rs_full_o = &valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            rs_sgn_q    <= 1'b0;
            rs_opcode_q <= '0;
            lhs_q       <= '0;
            rhs_q       <= '0;
            imm_out_q   <= '0;
            pc_out_q    <= '0;
            rob_entry_q <= '0;
        end else if (rollback_i) begin
            valid_q  <= '0;
            rs_sgn_q <= 1'b0;
        end else if (!rdy_i) begin
            rs_sgn_q <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i]) begin
                    jr_q[i] <= jr_d[i];
                    vj_q[i] <= vj_d[i];
                    kr_q[i] <= kr_d[i];
                    vk_q[i] <= vk_d[i];
                end
            end
            rs_sgn_q <= sel_found;
            if (sel_found) begin
                valid_q[sel_idx] <= 1'b0;
                rs_opcode_q      <= op_q[sel_idx];
                lhs_q            <= vj_d[sel_idx];
                rhs_q            <= vk_d[sel_idx];
                imm_out_q        <= imm_q[sel_idx];
                pc_out_q         <= pc_q[sel_idx];
                rob_entry_q      <= rob_q[sel_idx];
            end
            // The free slot is never the selected one, so both writes can share the edge.
            if (issue_sgn_i && !rs_full_o) begin
                valid_q[free_idx] <= 1'b1;
                op_q[free_idx]    <= issue_opcode_i;
                jr_q[free_idx]    <= iss_jr;
                vj_q[free_idx]    <= iss_vj;
                qj_q[free_idx]    <= issue_qj_i;
                kr_q[free_idx]    <= iss_kr;
                vk_q[free_idx]    <= iss_vk;
                qk_q[free_idx]    <= issue_qk_i;
                imm_q[free_idx]   <= issue_imm_i;
                pc_q[free_idx]    <= issue_pc_i;
                rob_q[free_idx]   <= issue_rob_i;
            end
        end
    end

    assign rs_sgn_o    = rs_sgn_q;
    assign rs_opcode_o = rs_opcode_q;
    assign lhs_o       = lhs_q;
    assign rhs_o       = rhs_q;
    assign imm_o       = imm_out_q;
    assign pc_o        = pc_out_q;
    assign rob_entry_o = rob_entry_q;
endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Scoreboard bench for rs_alu_scheduler: expected dispatches queued at stimulus time, popped on rs_sgn_o.
module tb_rs_alu_scheduler;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
`ifdef RS_WAKEUP_SELECT_EN
    localparam bit FUSED = 1'b1;
`else
    localparam bit FUSED = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, rdy_i, rollback_i;
    logic        issue_sgn_i, issue_j_rdy_i, issue_k_rdy_i;
    logic [5:0]  issue_opcode_i;
    logic [31:0] issue_vj_i, issue_vk_i, issue_imm_i, issue_pc_i;
    logic [3:0]  issue_qj_i, issue_qk_i, issue_rob_i;
    logic        rs_full_o;
    logic        alu_cdb_sgn_i, lsb_cdb_sgn_i;
    logic [3:0]  alu_cdb_rob_i, lsb_cdb_rob_i;
    logic [31:0] alu_cdb_val_i, lsb_cdb_val_i;
    logic        rs_sgn_o;
    logic [5:0]  rs_opcode_o;
    logic [31:0] lhs_o, rhs_o, imm_o, pc_o;
    logic [3:0]  rob_entry_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_disp  = 0;
    logic [159:0] sb_q[$];

    rs_alu_scheduler #(.RS_SIZE(16), .ROB_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rdy_i(rdy_i), .rollback_i(rollback_i),
        .issue_sgn_i(issue_sgn_i), .issue_opcode_i(issue_opcode_i),
        .issue_j_rdy_i(issue_j_rdy_i), .issue_vj_i(issue_vj_i), .issue_qj_i(issue_qj_i),
        .issue_k_rdy_i(issue_k_rdy_i), .issue_vk_i(issue_vk_i), .issue_qk_i(issue_qk_i),
        .issue_imm_i(issue_imm_i), .issue_pc_i(issue_pc_i), .issue_rob_i(issue_rob_i),
        .rs_full_o(rs_full_o),
        .alu_cdb_sgn_i(alu_cdb_sgn_i), .alu_cdb_rob_i(alu_cdb_rob_i), .alu_cdb_val_i(alu_cdb_val_i),
        .lsb_cdb_sgn_i(lsb_cdb_sgn_i), .lsb_cdb_rob_i(lsb_cdb_rob_i), .lsb_cdb_val_i(lsb_cdb_val_i),
        .rs_sgn_o(rs_sgn_o), .rs_opcode_o(rs_opcode_o), .lhs_o(lhs_o), .rhs_o(rhs_o),
        .imm_o(imm_o), .pc_o(pc_o), .rob_entry_o(rob_entry_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] pk(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r,
                                        input logic [31:0] im, input logic [31:0] p, input logic [3:0] rob);
        return {22'b0, op, l, r, im, p, rob};
    endfunction

    always @(negedge clk_i) begin
        if (rs_sgn_o) begin
            n_disp++;
            if (sb_q.size() == 0)
                check_eq("sb_unexpected_dispatch", 160'(rs_sgn_o), 160'(0));
            else
                check_eq("dispatch_fields", pk(rs_opcode_o, lhs_o, rhs_o, imm_o, pc_o, rob_entry_o),
                         sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_op(input logic [5:0] op, input logic jr, input logic [31:0] vj, input logic [3:0] qj,
                            input logic kr, input logic [31:0] vk, input logic [3:0] qk,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        issue_opcode_i = op;  issue_j_rdy_i = jr; issue_vj_i = vj; issue_qj_i = qj;
        issue_k_rdy_i  = kr;  issue_vk_i    = vk; issue_qk_i = qk;
        issue_imm_i    = imm; issue_pc_i    = pc; issue_rob_i = rob;
        issue_sgn_i    = 1'b1;
        tick();
        issue_sgn_i    = 1'b0;
    endtask

    task automatic clear_cdb();
        alu_cdb_sgn_i = 1'b0;
        lsb_cdb_sgn_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int c;
        rst_i = 1'b1; rdy_i = 1'b1; rollback_i = 1'b0; issue_sgn_i = 1'b0;
        issue_opcode_i = '0; issue_j_rdy_i = 1'b0; issue_k_rdy_i = 1'b0;
        issue_vj_i = '0; issue_vk_i = '0; issue_qj_i = '0; issue_qk_i = '0;
        issue_imm_i = '0; issue_pc_i = '0; issue_rob_i = '0;
        alu_cdb_sgn_i = 1'b0; alu_cdb_rob_i = '0; alu_cdb_val_i = '0;
        lsb_cdb_sgn_i = 1'b0; lsb_cdb_rob_i = '0; lsb_cdb_val_i = '0;

        // reset
        tick(); tick();
        rst_i = 1'b0;
        check_eq("rst_sgn", 160'(rs_sgn_o), 160'(0));
        check_eq("rst_full", 160'(rs_full_o), 160'(0));
        check_eq("rst_outputs", pk(rs_opcode_o, lhs_o, rhs_o, imm_o, pc_o, rob_entry_o), 160'(0));

        // ready ADD dispatches one cycle after issue, for exactly one cycle
        sb_q.push_back(pk(OP_ADD, 32'd5, 32'd7, 32'h10, 32'h100, 4'd3));
        issue_op(OP_ADD, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 32'h10, 32'h100, 4'd3);
        @(negedge clk_i); check_eq("add_not_same_cycle", 160'(rs_sgn_o), 160'(0));
        @(negedge clk_i); check_eq("add_dispatch", 160'(rs_sgn_o), 160'(1));
        @(negedge clk_i); check_eq("add_one_cycle", 160'(rs_sgn_o), 160'(0));

        // SUB waiting on tag 2; both CDBs broadcast tag 2, ALU value must win
        sb_q.push_back(pk(OP_SUB, 32'd9, 32'd3, 32'h20, 32'h104, 4'd5));
        issue_op(OP_SUB, 1'b0, 32'd0, 4'd2, 1'b1, 32'd3, 4'd0, 32'h20, 32'h104, 4'd5);
        tick();
        alu_cdb_sgn_i = 1'b1; alu_cdb_rob_i = 4'd2; alu_cdb_val_i = 32'd9;
        lsb_cdb_sgn_i = 1'b1; lsb_cdb_rob_i = 4'd2; lsb_cdb_val_i = 32'd4;
        tick();
        clear_cdb();
        @(negedge clk_i); check_eq("wake_lat_first", 160'(rs_sgn_o), 160'(FUSED));
        @(negedge clk_i); check_eq("wake_lat_second", 160'(rs_sgn_o), 160'(!FUSED));

        // issue-time bypass from both CDBs
        sb_q.push_back(pk(OP_ADD, 32'h77, 32'h33, 32'h30, 32'h108, 4'd9));
        alu_cdb_sgn_i = 1'b1; alu_cdb_rob_i = 4'd6;  alu_cdb_val_i = 32'h77;
        lsb_cdb_sgn_i = 1'b1; lsb_cdb_rob_i = 4'd13; lsb_cdb_val_i = 32'h33;
        issue_op(OP_ADD, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd13, 32'h30, 32'h108, 4'd9);
        clear_cdb();
        @(negedge clk_i); check_eq("bypass_not_same_cycle", 160'(rs_sgn_o), 160'(0));
        @(negedge clk_i); check_eq("bypass_dispatch", 160'(rs_sgn_o), 160'(1));

        // fill all 16 entries with waiting ops: entry 0 on tag 1, others on tag 8
        for (int i = 0; i < 16; i++)
            issue_op(OP_ADD, 1'b0, 32'd0, (i == 0) ? 4'd1 : 4'd8, 1'b1, 32'(100 + i), 4'd0,
                     32'(i * 4), 32'(32'h1000 + i * 4), 4'(i));
        check_eq("fill_full", 160'(rs_full_o), 160'(1));
        issue_op(OP_SUB, 1'b1, 32'hdead, 4'd0, 1'b1, 32'hbeef, 4'd0, 32'h0, 32'h0, 4'd15);
        check_eq("fill_still_full", 160'(rs_full_o), 160'(1));
        sb_q.push_back(pk(OP_ADD, 32'd11, 32'd100, 32'd0, 32'h1000, 4'd0));
        lsb_cdb_sgn_i = 1'b1; lsb_cdb_rob_i = 4'd1; lsb_cdb_val_i = 32'd11;
        tick();
        clear_cdb();
        c = 0;
        while (rs_full_o && c < 4) begin tick(); c++; end
        check_eq("full_drop", 160'(rs_full_o), 160'(0));
        sb_q.push_back(pk(OP_SUB, 32'h21, 32'h22, 32'h40, 32'h200, 4'd7));
        issue_op(OP_SUB, 1'b1, 32'h21, 4'd0, 1'b1, 32'h22, 4'd0, 32'h40, 32'h200, 4'd7);
        repeat (3) tick();
        for (int i = 1; i < 16; i++)
            sb_q.push_back(pk(OP_ADD, 32'h55, 32'(100 + i), 32'(i * 4), 32'(32'h1000 + i * 4), 4'(i)));
        alu_cdb_sgn_i = 1'b1; alu_cdb_rob_i = 4'd8; alu_cdb_val_i = 32'h55;
        tick();
        clear_cdb();
        repeat (20) tick();
        check_eq("fill_drain", 160'(sb_q.size()), 160'(0));

        // index priority: slots 1 and 4 ready together; 0,2,3 keep waiting on tag 10
        for (int i = 0; i < 5; i++)
            issue_op(OP_ADD, 1'b0, 32'd0, (i == 1 || i == 4) ? 4'd12 : 4'd10, 1'b1, 32'(200 + i), 4'd0,
                     32'd0, 32'(32'h2000 + i), 4'(i));
        sb_q.push_back(pk(OP_ADD, 32'h12, 32'd201, 32'd0, 32'h2001, 4'd1));
        sb_q.push_back(pk(OP_ADD, 32'h12, 32'd204, 32'd0, 32'h2004, 4'd4));
        alu_cdb_sgn_i = 1'b1; alu_cdb_rob_i = 4'd12; alu_cdb_val_i = 32'h12;
        tick();
        clear_cdb();
        c = 0;
        @(negedge clk_i);
        while (!rs_sgn_o && c < 4) begin @(negedge clk_i); c++; end
        check_eq("prio_first_seen", 160'(rs_sgn_o), 160'(1));
        check_eq("prio_first_rob", 160'(rob_entry_o), 160'(1));
        @(negedge clk_i);
        check_eq("prio_second_next", 160'(rs_sgn_o), 160'(1));
        check_eq("prio_second_rob", 160'(rob_entry_o), 160'(4));

        // wake slots 0,2,3 then rollback with a concurrent issue
        if (FUSED) sb_q.push_back(pk(OP_ADD, 32'h10, 32'd200, 32'd0, 32'h2000, 4'd0));
        alu_cdb_sgn_i = 1'b1; alu_cdb_rob_i = 4'd10; alu_cdb_val_i = 32'h10;
        tick();
        clear_cdb();
        rollback_i = 1'b1;
        issue_op(OP_SUB, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 32'h0, 32'h300, 4'd11);
        rollback_i = 1'b0;
        @(negedge clk_i);
        check_eq("rollback_sgn", 160'(rs_sgn_o), 160'(0));
        check_eq("rollback_full", 160'(rs_full_o), 160'(0));
        n0 = n_disp;
        repeat (5) tick();
        check_eq("rollback_no_dispatch", 160'(n_disp - n0), 160'(0));

        // stall: ready entry held for three stalled edges, dispatched the edge after rdy returns
        sb_q.push_back(pk(OP_ADD, 32'h41, 32'h42, 32'h50, 32'h400, 4'd12));
        issue_op(OP_ADD, 1'b1, 32'h41, 4'd0, 1'b1, 32'h42, 4'd0, 32'h50, 32'h400, 4'd12);
        rdy_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("stall_sgn", 160'(rs_sgn_o), 160'(0));
        end
        rdy_i = 1'b1;
        @(negedge clk_i); check_eq("stall_release_wait", 160'(rs_sgn_o), 160'(0));
        @(negedge clk_i); check_eq("stall_resume", 160'(rs_sgn_o), 160'(1));

        repeat (3) tick();
        check_eq("sb_empty", 160'(sb_q.size()), 160'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
